// File: rtl/dequantizer_stream.sv
// dequantizer_stream: widens signed quantised activations back into the
// accumulator domain as sat((in - zero_point) * scale << shift).
// Two-stage valid/ready pipeline with a runtime-loadable configuration.
module dequantizer_stream #(
    parameter int DATA_WIDTH = 8,
    parameter int ACC_WIDTH  = 32,
    parameter int SHIFT_W    = 5
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         cfg_we,
    input  logic signed [DATA_WIDTH-1:0] cfg_scale,
    input  logic signed [DATA_WIDTH-1:0] cfg_zero_point,
    input  logic        [SHIFT_W-1:0]    cfg_shift,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic signed [DATA_WIDTH-1:0] in_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic signed [ACC_WIDTH-1:0]  out_data,
    output logic                         out_sat,
    output logic                         busy
);

    // Exact product width and the widest possible shifted value.
    localparam int PW = 2*DATA_WIDTH + 1;
    localparam int WW = ACC_WIDTH + 2**SHIFT_W;

    logic signed [DATA_WIDTH-1:0] scale_r;
    logic signed [DATA_WIDTH-1:0] zp_r;
    logic        [SHIFT_W-1:0]    shift_r;

    logic                         vld_p1;
    logic signed [PW-1:0]         prod_p1;
    logic                         vld_p2;

    logic                         accept;
    logic                         load_p2;
    logic                         cfg_load;

    logic signed [DATA_WIDTH:0]   diff_c;
    logic signed [PW-1:0]         diff_ext;
    logic signed [PW-1:0]         scale_ext;
    logic signed [PW-1:0]         prod_c;
    logic signed [WW-1:0]         wide_ext;
    logic signed [WW-1:0]         wide_c;
    logic signed [ACC_WIDTH-1:0]  res_c;
    logic                         sat_c;

    // Clamp a wide signed value into ACC_WIDTH; MSB of the result is the clamp flag.
    // The value fits exactly when every bit from the ACC_WIDTH sign bit upward agrees.
    function automatic logic [ACC_WIDTH:0] sat_acc(input logic signed [WW-1:0] w);
        logic [WW-ACC_WIDTH:0] hi;
        hi = w[WW-1:ACC_WIDTH-1];
        if ((&hi) || !(|hi))
            return {1'b0, w[ACC_WIDTH-1:0]};
        else if (w[WW-1])
            return {1'b1, 1'b1, {(ACC_WIDTH-1){1'b0}}};
        else
            return {1'b1, 1'b0, {(ACC_WIDTH-1){1'b1}}};
    endfunction

    assign busy      = vld_p1 | vld_p2;
    assign out_valid = vld_p2;
    assign in_ready  = !rst && !cfg_we && (!vld_p1 || !vld_p2 || out_ready);
    assign accept    = in_valid & in_ready;
    assign load_p2   = vld_p1 & (!vld_p2 | out_ready);
    // Config only changes between beats, so every beat sees one consistent set.
    assign cfg_load  = cfg_we & !busy & !accept;

    // Stage 1 arithmetic (exact widths) and stage 2 shift/saturate.
    always_comb begin
        diff_c    = {in_data[DATA_WIDTH-1], in_data} - {zp_r[DATA_WIDTH-1], zp_r};
        diff_ext  = {{(PW-DATA_WIDTH-1){diff_c[DATA_WIDTH]}}, diff_c};
        scale_ext = {{(PW-DATA_WIDTH){scale_r[DATA_WIDTH-1]}}, scale_r};
        prod_c    = diff_ext * scale_ext;
        wide_ext  = {{(WW-PW){prod_p1[PW-1]}}, prod_p1};
        wide_c    = wide_ext <<< shift_r;
        {sat_c, res_c} = sat_acc(wide_c);
    end

    // Configuration registers; reset restores the identity transform.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scale_r <= DATA_WIDTH'(1);
            zp_r    <= '0;
            shift_r <= '0;
        end else if (cfg_load) begin
            scale_r <= cfg_scale;
            zp_r    <= cfg_zero_point;
            shift_r <= cfg_shift;
        end
    end

    // ---- stage 1: offset and scale ----
    // Stage 1 valid: fills on accept, empties when its beat moves to stage 2.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            vld_p1 <= 1'b0;
        else if (accept)
            vld_p1 <= 1'b1;
        else if (load_p2)
            vld_p1 <= 1'b0;
    end

    // Stage 1 product register, data only.
    always_ff @(posedge clk) begin
        if (accept)
            prod_p1 <= prod_c;
    end

    // ---- stage 2: shift, saturate, present ----
    // Stage 2 output register; holds steady while downstream stalls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p2   <= 1'b0;
            out_data <= '0;
            out_sat  <= 1'b0;
        end else if (load_p2) begin
            vld_p2   <= 1'b1;
            out_data <= res_c;
            out_sat  <= sat_c;
        end else if (out_ready) begin
            vld_p2   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_dequantizer_stream.sv
// Scoreboard bench for dequantizer_stream: stimulus pushes expected beats,
// a negedge monitor pops and compares whenever an output is presented.
module tb_dequantizer_stream;

    logic               clk = 1'b0;
    logic               rst;
    logic               cfg_we;
    logic signed [7:0]  cfg_scale;
    logic signed [7:0]  cfg_zero_point;
    logic        [4:0]  cfg_shift;
    logic               in_valid;
    logic               in_ready;
    logic signed [7:0]  in_data;
    logic               out_valid;
    logic               out_ready;
    logic signed [31:0] out_data;
    logic               out_sat;
    logic               busy;

    typedef struct {
        logic signed [31:0] data;
        logic               sat;
        int                 lat;
    } exp_t;

    exp_t sb[$];
    int   n_cmp   = 0;
    int   n_err   = 0;
    int   cyc     = 0;
    int   acc_cnt = 0;

    dequantizer_stream #(.DATA_WIDTH(8), .ACC_WIDTH(32), .SHIFT_W(5)) dut (
        .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_scale(cfg_scale),
        .cfg_zero_point(cfg_zero_point), .cfg_shift(cfg_shift),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_sat(out_sat), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Output monitor: compares every presented beat (also during stalls) with the queue head.
    always @(negedge clk) begin
        if (!rst) begin
            if (in_valid && in_ready) acc_cnt++;
            if (out_valid) begin
                if (sb.size() == 0) begin
                    chk("unexpected_out", {32'h0, out_data}, 64'hDEAD);
                end else begin
                    chk("out_data", out_data, sb[0].data);
                    chk("out_sat", out_sat, sb[0].sat);
                    if (out_ready) begin
                        if (sb[0].lat >= 0) chk("latency", cyc, sb[0].lat);
                        void'(sb.pop_front());
                    end
                end
            end
        end
    end

    task automatic send(input logic signed [7:0] d, input logic signed [31:0] ed,
                        input logic es, input bit chk_lat, output int acc_cyc);
        bit ok;
        ok = 1'b0;
        acc_cyc = -1;
        in_valid = 1'b1;
        in_data  = d;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        if (ok) begin
            acc_cyc = cyc;
            sb.push_back('{ed, es, chk_lat ? cyc + 2 : -1});
        end else begin
            chk("accept_timeout", 0, 1);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        bit done;
        done = 1'b0;
        for (int n = 0; n < 50; n++) begin
            @(posedge clk); #1;
            if (!busy && sb.size() == 0) begin
                done = 1'b1;
                break;
            end
        end
        chk("drain", done, 1);
    endtask

    task automatic cfg(input logic signed [7:0] s, input logic signed [7:0] z,
                       input logic [4:0] sh);
        cfg_we = 1'b1; cfg_scale = s; cfg_zero_point = z; cfg_shift = sh;
        @(posedge clk); #1;
        cfg_we = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int a, c0;
        rst = 1'b1; cfg_we = 1'b0; cfg_scale = '0; cfg_zero_point = '0; cfg_shift = '0;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
        repeat (2) @(posedge clk); #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_sat", out_sat, 0);
        chk("rst_busy", busy, 0);
        chk("rst_in_ready", in_ready, 0);
        rst = 1'b0;
        #1 chk("idle_in_ready", in_ready, 1);
        @(posedge clk); #1;

        // Identity config, back-to-back with latency checks.
        send(-128, -128, 0, 1, a);
        send(-5,   -5,   0, 1, a);
        send(127,  127,  0, 1, a);
        drain();

        // Stall: downstream blocks for 6 cycles while 5 beats are offered.
        fork
            begin
                for (int k = 1; k <= 5; k++) send(8'(k), 32'(k), 0, 0, a);
            end
            begin
                int a0;
                a0 = acc_cnt;
                out_ready = 1'b0;
                repeat (6) @(negedge clk);
                #1;
                chk("stall_accepts", acc_cnt - a0, 2);
                chk("stall_in_ready", in_ready, 0);
                @(posedge clk); #1;
                out_ready = 1'b1;
            end
        join
        drain();

        // Scaled and shifted.
        cfg(3, 2, 4);
        send(10, 384, 0, 0, a);
        send(-6, -384, 0, 0, a);
        drain();

        // Saturation boundaries.
        cfg(-128, 127, 31);
        send(-128, 32'sh7FFF_FFFF, 1, 0, a);
        send(127, 0, 0, 0, a);
        drain();
        cfg(127, 127, 31);
        send(-128, 32'sh8000_0000, 1, 0, a);
        drain();

        // Config write while busy is ignored.
        cfg(2, 0, 0);
        send(3, 6, 0, 0, a);
        chk("busy_after_accept", busy, 1);
        cfg(5, 0, 0);
        send(4, 8, 0, 0, a);
        drain();

        // Config write while idle blocks the input for that cycle only.
        cfg_we = 1'b1; cfg_scale = 5; cfg_zero_point = 0; cfg_shift = 0;
        in_valid = 1'b1; in_data = 4;
        @(negedge clk);
        chk("cfg_in_ready", in_ready, 0);
        @(posedge clk); #1;
        cfg_we = 1'b0;
        c0 = cyc;
        send(4, 20, 0, 1, a);
        chk("cfg_next_accept", a, c0);
        drain();

        // Asynchronous reset with two beats in flight.
        out_ready = 1'b0;
        send(2, 10, 0, 0, a);
        send(3, 15, 0, 0, a);
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_in_ready", in_ready, 0);
        sb.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        out_ready = 1'b1;
        send(7, 7, 0, 1, a);
        drain();
        chk("sb_empty", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
